// File: rtl/mbisr_remap.sv
// mbisr_remap: allocates spare word registers to failing addresses
// and steers functional accesses to repaired addresses into them.
module mbisr_remap #(
    parameter int ADDR_W     = 5,
    parameter int DATA_W     = 8,
    parameter int NUM_SPARES = 4,
    parameter int CNT_W      = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              clear,
    input  logic              fail_valid,
    input  logic [ADDR_W-1:0] fail_addr,
    output logic              fail_ready,
    input  logic              acc_en,
    input  logic              acc_we,
    input  logic [ADDR_W-1:0] acc_addr,
    input  logic [DATA_W-1:0] acc_wdata,
    output logic [DATA_W-1:0] acc_rdata,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              hit,
    output logic [CNT_W-1:0]  repair_count,
    output logic              repair_fail,
    output logic              busy
);

    typedef enum logic [1:0] {IDLE, LOOKUP, ALLOC} state_t;

    state_t                state;
    state_t                state_nx;
    logic [ADDR_W-1:0]     pend;
    logic [NUM_SPARES-1:0] vld;
    logic [ADDR_W-1:0]     tag  [NUM_SPARES];
    logic [DATA_W-1:0]     data [NUM_SPARES];
    logic [NUM_SPARES-1:0] acc_match;
    logic [NUM_SPARES-1:0] pend_match;
    logic [NUM_SPARES-1:0] alloc_oh;
    logic [DATA_W-1:0]     hit_data;
    logic                  dup;
    logic                  full;
    logic                  rd_req;
    logic                  wr_hit;
    logic                  rd_vld;
    logic                  rd_hit;
    logic [DATA_W-1:0]     rd_spare;
    logic [DATA_W-1:0]     rd_hold;

    always_comb begin
        acc_match  = '0;
        pend_match = '0;
        hit_data   = '0;
        for (int i = 0; i < NUM_SPARES; i++) begin
            acc_match[i]  = vld[i] && (tag[i] == acc_addr);
            pend_match[i] = vld[i] && (tag[i] == pend);
            if (acc_match[i]) hit_data = hit_data | data[i];
        end
    end

    // lowest clear bit of vld, one-hot
    assign alloc_oh = ~vld & (vld + NUM_SPARES'(1));
    assign dup      = |pend_match;
    assign full     = &vld;

    assign hit       = acc_en && (|acc_match);
    assign mem_en    = acc_en && !hit;
    assign mem_we    = acc_en && acc_we && !hit;
    assign mem_addr  = acc_addr;
    assign mem_wdata = acc_wdata;
    assign rd_req    = acc_en && !acc_we;
    assign wr_hit    = hit && acc_we;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (fail_valid) state_nx = LOOKUP;
            LOOKUP:  state_nx = (!dup && !full) ? ALLOC : IDLE;
            ALLOC:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
        if (clear) state_nx = IDLE;
    end

    always_comb begin
        fail_ready = (state == IDLE);
        busy       = (state != IDLE);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) pend <= '0;
        else if (state == IDLE && fail_valid) pend <= fail_addr;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vld <= '0;
            for (int i = 0; i < NUM_SPARES; i++) begin
                tag[i]  <= '0;
                data[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM_SPARES; i++)
                if (wr_hit && acc_match[i]) data[i] <= acc_wdata;
            if (clear) begin
                vld <= '0;
            end else if (state == ALLOC) begin
                for (int i = 0; i < NUM_SPARES; i++) begin
                    if (alloc_oh[i]) begin
                        vld[i]  <= 1'b1;
                        tag[i]  <= pend;
                        data[i] <= '0;
                    end
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            repair_count <= '0;
            repair_fail  <= 1'b0;
        end else if (clear) begin
            repair_count <= '0;
            repair_fail  <= 1'b0;
        end else begin
            if (state == ALLOC && repair_count != CNT_W'(NUM_SPARES))
                repair_count <= repair_count + CNT_W'(1);
            if (state == LOOKUP && !dup && full)
                repair_fail <= 1'b1;
        end
    end

    // read data is muxed one cycle later to line up with the SRAM
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_vld   <= 1'b0;
            rd_hit   <= 1'b0;
            rd_spare <= '0;
            rd_hold  <= '0;
        end else begin
            rd_vld <= rd_req;
            if (rd_req) begin
                rd_hit   <= hit;
                rd_spare <= hit_data;
            end
            if (rd_vld) rd_hold <= acc_rdata;
        end
    end

    assign acc_rdata = rd_vld ? (rd_hit ? rd_spare : mem_rdata) : rd_hold;

endmodule

// File: tb/tb_mbisr_remap.sv
// Bench for mbisr_remap: directed plan items plus randomized traffic
// compared every cycle against a report-level behavioural model.
module tb_mbisr_remap;

    localparam int NS = 4;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       clear = 1'b0;
    logic       fail_valid = 1'b0;
    logic [4:0] fail_addr = '0;
    logic       fail_ready;
    logic       acc_en = 1'b0;
    logic       acc_we = 1'b0;
    logic [4:0] acc_addr = '0;
    logic [7:0] acc_wdata = '0;
    logic [7:0] acc_rdata;
    logic       mem_en;
    logic       mem_we;
    logic [4:0] mem_addr;
    logic [7:0] mem_wdata;
    logic [7:0] mem_rdata = '0;
    logic       hit;
    logic [2:0] repair_count;
    logic       repair_fail;
    logic       busy;

    int n_checks = 0;
    int n_errors = 0;

    mbisr_remap #(
        .ADDR_W(5), .DATA_W(8), .NUM_SPARES(NS), .CNT_W(3)
    ) dut (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .fail_valid(fail_valid), .fail_addr(fail_addr),
        .fail_ready(fail_ready),
        .acc_en(acc_en), .acc_we(acc_we), .acc_addr(acc_addr),
        .acc_wdata(acc_wdata), .acc_rdata(acc_rdata),
        .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
        .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .hit(hit), .repair_count(repair_count),
        .repair_fail(repair_fail), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string n, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", n, act, exp);
        end
    endtask

    // behavioural model: a report's outcome is decided when it is accepted
    bit         mv [NS];
    logic [4:0] mt [NS];
    logic [7:0] md [NS];
    int         mcount;
    bit         mfail;
    int         bcnt;
    int         pact;
    int         pidx;
    logic [4:0] mpend;
    bit         rd_p;
    bit         rd_h;
    logic [7:0] rd_d;
    logic [7:0] last;

    function automatic int find(input logic [4:0] a);
        int r = -1;
        for (int i = 0; i < NS; i++)
            if (mv[i] && mt[i] == a) r = i;
        return r;
    endfunction

    function automatic int lowest_free();
        int r = -1;
        for (int i = NS - 1; i >= 0; i--)
            if (!mv[i]) r = i;
        return r;
    endfunction

    task automatic model_reset();
        for (int i = 0; i < NS; i++) begin
            mv[i] = 0; mt[i] = '0; md[i] = '0;
        end
        mcount = 0; mfail = 0; bcnt = 0; pact = 0; pidx = 0;
        mpend = '0; rd_p = 0; rd_h = 0; rd_d = '0; last = '0;
    endtask

    task automatic model_step();
        int ai;
        int fi;
        ai = find(acc_addr);
        if (rd_p) last = rd_h ? rd_d : mem_rdata;
        rd_p = acc_en && !acc_we;
        if (rd_p) begin
            rd_h = (ai >= 0);
            rd_d = (ai >= 0) ? md[ai] : 8'h00;
        end
        if (acc_en && acc_we && ai >= 0) md[ai] = acc_wdata;
        if (clear) begin
            for (int i = 0; i < NS; i++) mv[i] = 0;
            mcount = 0; mfail = 0; bcnt = 0;
        end else if (bcnt > 0) begin
            bcnt--;
            if (bcnt == 0 && pact == 1) begin
                mv[pidx] = 1; mt[pidx] = mpend; md[pidx] = '0;
                mcount++;
            end else if (bcnt == 0 && pact == 2) begin
                mfail = 1;
            end
        end else if (fail_valid) begin
            mpend = fail_addr;
            fi = lowest_free();
            if (find(fail_addr) >= 0) begin
                pact = 0; bcnt = 1;
            end else if (fi >= 0) begin
                pact = 1; pidx = fi; bcnt = 2;
            end else begin
                pact = 2; bcnt = 1;
            end
        end
    endtask

    always @(negedge clk) begin
        bit e_hit;
        if (!rst_n) model_reset();
        e_hit = acc_en && (find(acc_addr) >= 0);
        chk("fail_ready", fail_ready, bcnt == 0);
        chk("busy", busy, bcnt != 0);
        chk("hit", hit, e_hit);
        chk("mem_en", mem_en, acc_en && !e_hit);
        chk("mem_we", mem_we, acc_en && acc_we && !e_hit);
        chk("mem_addr", mem_addr, acc_addr);
        chk("mem_wdata", mem_wdata, acc_wdata);
        chk("repair_count", repair_count, mcount);
        chk("repair_fail", repair_fail, mfail);
        chk("acc_rdata", acc_rdata,
            rd_p ? (rd_h ? rd_d : mem_rdata) : last);
        if (rst_n) model_step();
    end

    task automatic tick();
        @(posedge clk);
        #1;
        mem_rdata = 8'($urandom);
    endtask

    task automatic look();
        #3;
    endtask

    task automatic quiet();
        fail_valid = 0; clear = 0; acc_en = 0; acc_we = 0;
    endtask

    task automatic report(input logic [4:0] a, input int cycles);
        fail_valid = 1; fail_addr = a;
        tick();
        fail_valid = 0;
        repeat (cycles - 1) tick();
    endtask

    task automatic do_clear();
        clear = 1; tick(); clear = 0;
    endtask

    initial begin
        quiet();
        tick(); look();
        chk("rst_ready", fail_ready, 1);
        chk("rst_busy", busy, 0);
        chk("rst_count", repair_count, 0);
        chk("rst_fail", repair_fail, 0);
        chk("rst_rdata", acc_rdata, 0);
        chk("rst_hit", hit, 0);
        tick();
        rst_n = 1;

        // single report, then write/read through the spare
        fail_valid = 1; fail_addr = 5'd7; look();
        chk("t1_ready_idle", fail_ready, 1);
        tick(); fail_valid = 0; look();
        chk("t1_ready_lookup", fail_ready, 0);
        tick(); look();
        chk("t1_ready_alloc", fail_ready, 0);
        chk("t1_busy_alloc", busy, 1);
        tick(); look();
        chk("t1_ready_back", fail_ready, 1);
        chk("t1_count", repair_count, 1);
        acc_en = 1; acc_we = 1; acc_addr = 5'd7; acc_wdata = 8'hA5; look();
        chk("t1_wr_hit", hit, 1);
        chk("t1_wr_mem_we", mem_we, 0);
        chk("t1_wr_mem_en", mem_en, 0);
        tick(); acc_we = 0; look();
        chk("t1_rd_hit", hit, 1);
        tick(); quiet(); look();
        chk("t1_rdata", acc_rdata, 8'hA5);

        // unrepaired read goes to SRAM
        acc_en = 1; acc_we = 0; acc_addr = 5'd5; look();
        chk("t4_mem_en", mem_en, 1);
        chk("t4_hit", hit, 0);
        tick(); quiet(); mem_rdata = 8'h3C; look();
        chk("t4_rdata", acc_rdata, 8'h3C);
        tick();

        // duplicate report allocates nothing
        do_clear();
        report(5'd3, 3);
        fail_valid = 1; fail_addr = 5'd3; look();
        chk("t2_dup_ready0", fail_ready, 1);
        tick(); fail_valid = 0; look();
        chk("t2_dup_ready1", fail_ready, 0);
        tick(); look();
        chk("t2_dup_ready2", fail_ready, 1);
        chk("t2_dup_count", repair_count, 1);
        report(5'd9, 3); look();
        chk("t2_count", repair_count, 2);

        // overflow sets sticky fail
        do_clear();
        report(5'd1, 3); report(5'd2, 3); report(5'd4, 3); report(5'd8, 3);
        look();
        chk("t3_count4", repair_count, 4);
        report(5'd16, 2); look();
        chk("t3_fail", repair_fail, 1);
        chk("t3_count_sat", repair_count, 4);
        acc_en = 1; acc_we = 1; acc_addr = 5'd16; look();
        chk("t3_hit16", hit, 0);
        chk("t3_mem_en16", mem_en, 1);
        chk("t3_mem_we16", mem_we, 1);
        tick(); quiet();

        // access during the allocation cycle sees the old map
        do_clear();
        fail_valid = 1; fail_addr = 5'd12; tick();
        fail_valid = 0; tick();
        acc_en = 1; acc_we = 0; acc_addr = 5'd12; look();
        chk("t5_hit_alloc", hit, 0);
        chk("t5_busy_alloc", busy, 1);
        tick(); look();
        chk("t5_hit_after", hit, 1);
        tick();
        acc_we = 1; acc_wdata = 8'h5A; tick();
        acc_we = 0; tick(); quiet(); look();
        chk("t5_raw", acc_rdata, 8'h5A);
        tick(); look();
        chk("t5_hold", acc_rdata, 8'h5A);

        // clear beats a simultaneous report
        do_clear();
        report(5'd3, 3); report(5'd9, 3); look();
        chk("t6_count2", repair_count, 2);
        clear = 1; fail_valid = 1; fail_addr = 5'd20; tick();
        quiet(); look();
        chk("t6_count0", repair_count, 0);
        chk("t6_fail0", repair_fail, 0);
        acc_en = 1; acc_addr = 5'd3; look();
        chk("t6_hit_old", hit, 0);
        tick(); quiet();
        repeat (3) tick();
        look();
        chk("t6_dropped", repair_count, 0);
        chk("t6_idle", busy, 0);

        // asynchronous reset in the middle of a report
        report(5'd6, 3);
        fail_valid = 1; fail_addr = 5'd10; tick();
        fail_valid = 0; rst_n = 0; look();
        chk("ar_busy", busy, 0);
        chk("ar_count", repair_count, 0);
        tick(); rst_n = 1; tick();

        for (int c = 0; c < 3000; c++) begin
            fail_valid = ($urandom_range(0, 2) == 0);
            fail_addr  = 5'($urandom_range(0, 11));
            clear      = ($urandom_range(0, 49) == 0);
            acc_en     = ($urandom_range(0, 9) < 6);
            acc_we     = $urandom_range(0, 1) == 1;
            acc_addr   = 5'($urandom_range(0, 15));
            acc_wdata  = 8'($urandom);
            rst_n      = ($urandom_range(0, 299) != 0);
            tick();
        end
        quiet(); rst_n = 1;
        tick(); tick();

        $display("Simulation finished: %0d checks, %0d errors",
                 n_checks, n_errors);
        $finish;
    end

endmodule
